// File: rtl/cache_fill_fsm.sv
// Cache miss handler: stalls the requesting stage and fills one aligned block from pipelined memory.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start the fill at the missing word and wrap around the block.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        memory_req,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [15:0] fill_word_addr,
  output logic [15:0] fill_data,
  output logic        write_tag_array
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [15:0]      OFS_MASK = 16'(2 * BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e           state_q, state_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [IDX_W-1:0] issue_word, ret_word;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] start_q, start_d;

  // Word index wraps naturally in IDX_W bits, so offsets never carry out of the block.
  always_comb begin
    issue_word = issue_cnt_q[IDX_W-1:0] + start_q;
    ret_word   = ret_cnt_q[IDX_W-1:0] + start_q;
  end
`else
  always_comb begin
    issue_word = issue_cnt_q[IDX_W-1:0];
    ret_word   = ret_cnt_q[IDX_W-1:0];
  end
`endif

  assign fill_data = memory_data;

  always_comb begin
    // NOTE: every next-state and output gets a default first, so no path through the case infers a latch.
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start_d          = start_q;
`endif
    fsm_busy         = 1'b0;
    memory_req       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_addr   = '0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Combinational so the missing access stalls in the cycle it misses.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_d     = FILL;
          base_d      = miss_address & ~OFS_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
          start_d     = miss_address[IDX_W:1];
`endif
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < FULL_CNT) begin
          memory_req     = 1'b1;
          memory_address = base_q + 16'({issue_word, 1'b0});
          issue_cnt_d    = issue_cnt_q + 1'b1;
        end
        // Returns are tracked independently of issues; they may overlap or arrive with gaps.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word_addr   = base_q + 16'({ret_word, 1'b0});
          ret_cnt_d        = ret_cnt_q + 1'b1;
          if (ret_cnt_q == LAST_CNT) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk) begin
    if (rst) start_q <= '0;
    else     start_q <= start_d;
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a latency-L memory model feeds returns, a negedge monitor checks outputs.
module tb_cache_fill_fsm;

  localparam int BW = 8;
  localparam int L  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy, memory_req, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_word_addr, fill_data;

  cache_fill_fsm #(.BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .memory_req(memory_req), .memory_address(memory_address),
    .write_data_array(write_data_array), .fill_word_addr(fill_word_addr),
    .fill_data(fill_data), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } pend_t;

  logic [15:0] req_q[$];
  logic [15:0] wr_q[$];
  pend_t       pend[$];

  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  t_miss = 0;
  int  wr_cnt = 0;
  int  gap_mode = 0;
  bit  model_fill = 1'b0;
  logic [0:10] gap_pat = 11'b10110011111;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Address of the n-th word of the fill, from the block/ordering rules alone.
  function automatic logic [15:0] exp_addr(input logic [15:0] a, input int n);
    logic [15:0] base;
    int start;
    base  = a & ~16'(2 * BW - 1);
    start = 0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start = int'(a >> 1) % BW;
`endif
    return base + 16'(2 * ((start + n) % BW));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and scoreboard, sampled mid-cycle.
  bit          fill_now, exp_req, exp_wr, exp_tag;
  logic [15:0] e;
  always @(negedge clk) begin
    if (rst) begin
      req_q.delete();
      wr_q.delete();
      pend.delete();
      model_fill = 1'b0;
      wr_cnt     = 0;
    end else begin
      fill_now = model_fill;
      exp_tag  = 1'b0;
      check("fsm_busy", fsm_busy, fill_now || miss_detected);

      exp_req = fill_now && (req_q.size() != 0);
      check("memory_req", memory_req, exp_req);
      if (memory_req && exp_req) begin
        e = req_q.pop_front();
        check("memory_address", memory_address, e);
        pend.push_back('{addr: e, ready: cyc + L});
      end else begin
        check("memory_address_idle", memory_address, 16'h0);
      end

      exp_wr = fill_now && memory_data_valid && (wr_q.size() != 0);
      check("write_data_array", write_data_array, exp_wr);
      if (exp_wr) begin
        e = wr_q.pop_front();
        check("fill_word_addr", fill_word_addr, e);
        check("fill_data", fill_data, mem_word(e));
        wr_cnt++;
        exp_tag = (wr_q.size() == 0);
      end else begin
        check("fill_word_addr_idle", fill_word_addr, 16'h0);
      end

      check("write_tag_array", write_tag_array, exp_tag);
      if (exp_tag) begin
        check("writes_per_fill", wr_cnt, BW);
        if (gap_mode == 0) check("tag_cycle", cyc, t_miss + L + BW);
        model_fill = 1'b0;
      end

      if (!fill_now && miss_detected) begin
        model_fill = 1'b1;
        wr_cnt     = 0;
      end
    end
  end

  // Advance one cycle, then drive default inputs and the memory model's return for this cycle.
  task automatic tick();
    pend_t p;
    int    idx;
    bit    go;
    @(posedge clk);
    #1;
    miss_detected     = 1'b0;
    miss_address      = 16'($urandom);
    memory_data_valid = 1'b0;
    memory_data       = 16'($urandom);
    if (pend.size() != 0 && pend[0].ready <= cyc) begin
      go = 1'b1;
      if (gap_mode == 1) begin
        go = ($urandom_range(0, 2) != 0);
      end else if (gap_mode == 2) begin
        idx = cyc - (t_miss + 1 + L);
        go  = (idx >= 0 && idx < 11) ? gap_pat[idx] : 1'b1;
      end
      if (go) begin
        p = pend.pop_front();
        memory_data_valid = 1'b1;
        memory_data       = mem_word(p.addr);
      end
    end
  endtask

  task automatic issue_miss(input logic [15:0] a);
    miss_detected = 1'b1;
    miss_address  = a;
    if (!model_fill) begin
      t_miss = cyc;
      for (int n = 0; n < BW; n++) begin
        req_q.push_back(exp_addr(a, n));
        wr_q.push_back(exp_addr(a, n));
      end
    end
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input bit noise);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!model_fill) break;
      if (noise && $urandom_range(0, 4) == 0) begin
        miss_detected = 1'b1;
        miss_address  = 16'($urandom);
      end
    end
    check("fill_completes", model_fill, 1'b0);
    if (model_fill) do_reset();
  endtask

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Aligned-block fill from the middle of a block, no return gaps.
    gap_mode = 0;
    issue_miss(16'h1236);
    wait_idle(1'b0);

    // Return gaps following a fixed valid pattern.
    tick();
    gap_mode = 2;
    issue_miss(16'h2468);
    wait_idle(1'b0);

    // Mid-fill miss is ignored; valid pulse in IDLE is ignored.
    gap_mode = 0;
    tick();
    issue_miss(16'h4A10);
    repeat (3) tick();
    miss_detected = 1'b1;
    miss_address  = 16'h7777;
    wait_idle(1'b0);
    tick();
    memory_data_valid = 1'b1;
    repeat (3) tick();

    // Reset after three returns, then a fill at the top of the address space.
    issue_miss(16'h5550);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (wr_cnt >= 3) break;
    end
    do_reset();
    repeat (3) tick();
    issue_miss(16'hFFF2);
    wait_idle(1'b0);

    // Back-to-back misses: the next miss lands in the first IDLE cycle.
    issue_miss(16'h0A0C);
    wait_idle(1'b0);
    issue_miss(16'hBEEE);
    wait_idle(1'b0);

    // Randomized fills with random gaps, idle spacing, stray valids and stray misses.
    gap_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int idle_cycles;
      idle_cycles = $urandom_range(0, 3);
      for (int k = 0; k < idle_cycles; k++) begin
        tick();
        memory_data_valid = ($urandom_range(0, 1) == 1);
      end
      issue_miss(16'($urandom));
      wait_idle(1'b1);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
